// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: AR/R read channel, decode-side instruction handshake and redirect input.
// The master modport is the fetch unit; the slave modport is memory plus decode plus branch resolution.
interface ifu_fetch_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 o_arvalid;
  logic [CPU_WIDTH-1:0] o_araddr;
  logic                 i_arready;
  logic                 i_rvalid;
  logic [CPU_WIDTH-1:0] i_rdata;
  logic [1:0]           i_rresp;
  logic                 o_rready;
  logic [CPU_WIDTH-1:0] o_instr;
  logic [CPU_WIDTH-1:0] o_pc;
  logic                 o_post_valid;
  logic                 i_post_ready;
  logic                 o_fetch_err;
  logic                 i_redirect_valid;
  logic [CPU_WIDTH-1:0] i_redirect_pc;

  modport master (
    output o_arvalid, o_araddr, o_rready, o_instr, o_pc, o_post_valid, o_fetch_err,
    input  i_arready, i_rvalid, i_rdata, i_rresp, i_post_ready, i_redirect_valid, i_redirect_pc
  );

  modport slave (
    input  o_arvalid, o_araddr, o_rready, o_instr, o_pc, o_post_valid, o_fetch_err,
    output i_arready, i_rvalid, i_rdata, i_rresp, i_post_ready, i_redirect_valid, i_redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding AR/R reads, valid/ready hand-off to decode,
// and PC redirect with squashing of the wrong-path response already on the bus.
module ifu_fetch #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input logic        i_clk,
  input logic        i_rst_n,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    HOLD
  } state_e;

  state_e               state_q,      state_d;
  logic [CPU_WIDTH-1:0] pc_q,         pc_d;
  logic [CPU_WIDTH-1:0] tgt_q,        tgt_d;
  logic                 drop_q,       drop_d;
  logic                 arvalid_q,    arvalid_d;
  logic                 rready_q,     rready_d;
  logic                 post_valid_q, post_valid_d;
  logic [CPU_WIDTH-1:0] instr_q,      instr_d;
  logic [CPU_WIDTH-1:0] opc_q,        opc_d;
  logic                 err_q,        err_d;

  logic [CPU_WIDTH-1:0] redir_pc;
  logic [CPU_WIDTH-1:0] pc_plus4;
  logic                 beat_err;

  assign redir_pc = bus.i_redirect_pc & ~(CPU_WIDTH'(3));
  assign pc_plus4 = pc_q + CPU_WIDTH'(4);
  assign beat_err = (bus.i_rresp != 2'b00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      tgt_q        <= RESET_PC;
      drop_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      post_valid_q <= 1'b0;
      instr_q      <= '0;
      opc_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      drop_q       <= drop_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      post_valid_q <= post_valid_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    drop_d       = drop_q;
    post_valid_d = post_valid_q;
    instr_d      = instr_q;
    opc_d        = opc_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        state_d = AR;
        if (bus.i_redirect_valid) begin
          pc_d = redir_pc;
        end
      end

      // The address is frozen while arvalid is up, so a redirect here is parked in tgt_q
      // and the response of the already-issued request gets thrown away.
      AR: begin
        if (bus.i_redirect_valid) begin
          tgt_d  = redir_pc;
          drop_d = 1'b1;
        end
        if (bus.i_arready) begin
          state_d = R;
        end
      end

      R: begin
        if (bus.i_rvalid) begin
          if (bus.i_redirect_valid) begin
            pc_d    = redir_pc;
            drop_d  = 1'b0;
            state_d = AR;
          end else if (drop_q) begin
            pc_d    = tgt_q;
            drop_d  = 1'b0;
            state_d = AR;
          end else begin
            instr_d      = beat_err ? '0 : bus.i_rdata;
            opc_d        = pc_q;
            err_d        = beat_err;
            post_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (bus.i_redirect_valid) begin
          tgt_d  = redir_pc;
          drop_d = 1'b1;
        end
      end

      // A redirect coinciding with the decode handshake still completes it; only pc differs.
      HOLD: begin
        if (bus.i_redirect_valid) begin
          pc_d         = redir_pc;
          post_valid_d = 1'b0;
          state_d      = AR;
        end else if (bus.i_post_ready) begin
          pc_d         = pc_plus4;
          post_valid_d = 1'b0;
          state_d      = AR;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    arvalid_d = (state_d == AR);
    rready_d  = (state_d == R);
  end

  assign bus.o_arvalid    = arvalid_q;
  assign bus.o_araddr     = pc_q;
  assign bus.o_rready     = rready_q;
  assign bus.o_instr      = instr_q;
  assign bus.o_pc         = opc_q;
  assign bus.o_post_valid = post_valid_q;
  assign bus.o_fetch_err  = err_q;

  a_araddr_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (arvalid_q && !bus.i_arready) |=> (arvalid_q && $stable(pc_q)));

  a_single_outstanding : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(arvalid_q && (rready_q || post_valid_q)));

  a_pc_aligned : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (pc_q[1:0] == 2'b00));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a bus slave answers reads, a monitor pops expected
// addresses and beats from scoreboard queues filled by the stimulus sequence.
module tb_ifu_fetch;

  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] errAddr = 32'h0000_0001;
  int          vectors = 0;
  int          miscompares = 0;
  int          popCount = 0;
  beat_t       expQ[$];
  logic [31:0] arQ[$];

  ifu_fetch_if #(.CPU_WIDTH(W)) bus ();

  ifu_fetch #(.CPU_WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive every bench-owned input for one cycle and return 1 time unit after the next edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] target,
                               input logic arRdy, input logic postRdy);
    bus.i_redirect_valid = redir;
    bus.i_redirect_pc    = target;
    bus.i_arready        = arRdy;
    bus.i_post_ready     = postRdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".arvalid"},    bus.o_arvalid, 0);
    checkOutput({tag, ".araddr"},     bus.o_araddr, RESET_PC);
    checkOutput({tag, ".rready"},     bus.o_rready, 0);
    checkOutput({tag, ".post_valid"}, bus.o_post_valid, 0);
    checkOutput({tag, ".fetch_err"},  bus.o_fetch_err, 0);
    checkOutput({tag, ".instr"},      bus.o_instr, 0);
    checkOutput({tag, ".pc"},         bus.o_pc, 0);
  endtask

  task automatic waitPops(input int target, input int budget);
    for (int i = 0; i < budget && popCount < target; i++) applyStimulus(0, 0, 1, 1);
    checkOutput("popsReached", popCount >= target, 1);
  endtask

  task automatic waitValid(input logic postRdy, input int budget);
    for (int i = 0; i < budget && !bus.o_post_valid; i++) applyStimulus(0, 0, 1, postRdy);
    checkOutput("validSeen", bus.o_post_valid, 1);
  endtask

  task automatic waitPc(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && !(bus.o_post_valid && bus.o_pc == target); i++)
      applyStimulus(0, 0, 1, 1);
    checkOutput("pcSeen", bus.o_pc, target);
  endtask

  function automatic void pushBeat(input logic [31:0] pc, input logic err);
    beat_t b;
    b.pc    = pc;
    b.err   = err;
    b.instr = err ? 32'h0 : memWord(pc);
    expQ.push_back(b);
  endfunction

  // Memory slave: answers one cycle after address acceptance; errAddr yields SLVERR with junk data.
  initial begin
    logic        accAr, accR;
    logic [31:0] addr;
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.i_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      accAr = bus.o_arvalid && bus.i_arready;
      accR  = bus.i_rvalid && bus.o_rready;
      addr  = bus.o_araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = '0;
        bus.i_rresp  = 2'b00;
      end else begin
        if (accR) bus.i_rvalid = 1'b0;
        if (accAr) begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = (addr == errAddr) ? 32'hBAD0_BAD0 : memWord(addr);
          bus.i_rresp  = (addr == errAddr) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Monitor: checks every AR acceptance and every decode handshake against the queues.
  initial begin
    logic        arPend;
    logic [31:0] holdAddr;
    beat_t       e;
    arPend   = 1'b0;
    holdAddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arPend = 1'b0;
      end else begin
        if (arPend) begin
          checkOutput("arAddrStable", bus.o_araddr, holdAddr);
          checkOutput("arValidHeld", bus.o_arvalid, 1);
        end
        if (bus.o_post_valid) checkOutput("noArInHold", bus.o_arvalid, 0);
        if (bus.o_arvalid && bus.i_arready) begin
          if (arQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL arUnexpected: got araddr 0x%08h, expected no request", bus.o_araddr);
          end else begin
            checkOutput("arAddr", bus.o_araddr, arQ.pop_front());
          end
        end
        arPend   = bus.o_arvalid && !bus.i_arready;
        holdAddr = bus.o_araddr;
        if (bus.o_post_valid && bus.i_post_ready) begin
          popCount++;
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL beatUnexpected: got pc 0x%08h, expected no beat", bus.o_pc);
          end else begin
            e = expQ.pop_front();
            checkOutput("beatPc", bus.o_pc, e.pc);
            checkOutput("beatInstr", bus.o_instr, e.instr);
            checkOutput("beatErr", bus.o_fetch_err, e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_arready        = 1'b1;
    bus.i_post_ready     = 1'b1;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");

    // Zero-wait memory: first request, latency, then three sequential beats.
    for (int i = 0; i < 4; i++) begin
      arQ.push_back(RESET_PC + 32'(4 * i));
      pushBeat(RESET_PC + 32'(4 * i), 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("firstArvalid", bus.o_arvalid, 1);
    checkOutput("firstAraddr", bus.o_araddr, RESET_PC);
    @(posedge clk); #1;
    checkOutput("firstRready", bus.o_rready, 1);
    checkOutput("earlyValid", bus.o_post_valid, 0);
    @(posedge clk); #1;
    checkOutput("firstValid", bus.o_post_valid, 1);
    checkOutput("firstPc", bus.o_pc, RESET_PC);
    checkOutput("firstInstr", bus.o_instr, memWord(RESET_PC));
    waitPops(3, 40);

    // Decode stalls for five cycles on the 0x8000_000C beat.
    applyStimulus(0, 0, 1, 0);
    waitValid(1'b0, 20);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("stallValid", bus.o_post_valid, 1);
      checkOutput("stallPc", bus.o_pc, 32'h8000_000C);
      checkOutput("stallInstr", bus.o_instr, memWord(32'h8000_000C));
      checkOutput("stallNoAr", bus.o_arvalid, 0);
    end

    // arready low three cycles with a redirect in cycle 2: 0x10 response is squashed.
    arQ.push_back(32'h8000_0010);
    arQ.push_back(32'h8000_0100);
    pushBeat(32'h8000_0100, 1'b0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stallNextAr", bus.o_araddr, 32'h8000_0010);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 32'h8000_0103, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("frozenAraddr", bus.o_araddr, 32'h8000_0010);
    applyStimulus(0, 0, 1, 1);
    waitValid(1'b1, 20);
    checkOutput("redirPc", bus.o_pc, 32'h8000_0100);

    // Redirect coinciding with the HOLD handshake, followed by an error beat.
    errAddr = 32'h8000_0044;
    for (int i = 0; i < 4; i++) arQ.push_back(32'h8000_0040 + 32'(4 * i));
    pushBeat(32'h8000_0040, 1'b0);
    pushBeat(32'h8000_0044, 1'b1);
    pushBeat(32'h8000_0048, 1'b0);
    pushBeat(32'h8000_004C, 1'b0);
    applyStimulus(1, 32'h8000_0040, 1, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("handshakeOnce", popCount, 5);

    // Redirect near the top of the address space, then wrap to zero.
    waitPc(32'h8000_004C, 40);
    arQ.push_back(32'hFFFF_FFFC);
    arQ.push_back(32'h0000_0000);
    pushBeat(32'hFFFF_FFFC, 1'b0);
    applyStimulus(1, 32'hFFFF_FFFE, 1, 1);
    applyStimulus(0, 0, 1, 1);
    waitPc(32'hFFFF_FFFC, 20);
    for (int i = 0; i < 20 && !bus.o_rready; i++) applyStimulus(0, 0, 1, 1);
    checkOutput("wrapInR", bus.o_rready, 1);

    // Reset asserted in R with a response on the bus clears everything at once.
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");
    checkOutput("expQDrained", expQ.size(), 0);
    checkOutput("arQDrained", arQ.size(), 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rearmArvalid", bus.o_arvalid, 1);
    checkOutput("rearmAraddr", bus.o_araddr, RESET_PC);
    checkOutput("rearmRready", bus.o_rready, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("staleIgnored", bus.o_post_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
